// File: rtl/unpack_cit_poly_decompress_pkg.sv
// Shared constants and state encoding for the ciphertext v-polynomial unpacker.
// D_BITS=3 fixes the packing at 8 coefficients per 3 bytes.
package unpack_cit_poly_decompress_pkg;

  localparam int KYBER_N          = 256;
  localparam int KYBER_Q          = 3329;
  localparam int D_BITS           = 3;
  localparam int COEFF_W          = 12;
  localparam int BYTES_PER_GROUP  = 3;
  localparam int COEFFS_PER_GROUP = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/unpack_cit_poly_decompress_if.sv
// Byte-in / coefficient-out handshake bundle for the unpacker.
// The slave side is the unpacker; the master side is the surrounding datapath.
interface unpack_cit_poly_decompress_if;
  import unpack_cit_poly_decompress_pkg::*;

  logic               i_Start;
  logic [7:0]         i_Byte;
  logic               i_Byte_Valid;
  logic               o_Byte_Ready;
  logic [COEFF_W-1:0] o_Coeff;
  logic [7:0]         o_Coeff_Idx;
  logic               o_Coeff_Valid;
  logic               i_Coeff_Ready;
  logic               o_Busy;
  logic               o_Done;

  modport slave (
    input  i_Start, i_Byte, i_Byte_Valid, i_Coeff_Ready,
    output o_Byte_Ready, o_Coeff, o_Coeff_Idx, o_Coeff_Valid, o_Busy, o_Done
  );

  modport master (
    output i_Start, i_Byte, i_Byte_Valid, i_Coeff_Ready,
    input  o_Byte_Ready, o_Coeff, o_Coeff_Idx, o_Coeff_Valid, o_Busy, o_Done
  );

endinterface

// File: rtl/unpack_cit_poly_decompress_decompress_d3.sv
// Combinational 3-bit to 12-bit decompression: round(x * Q / 8) computed as (x*Q + 4) >> 3.
// The worst case 7*3329+4 = 23307 fits the 15-bit intermediate.
module decompress_d3
  import unpack_cit_poly_decompress_pkg::*;
(
  input  logic [D_BITS-1:0]  x_i,
  output logic [COEFF_W-1:0] coeff_o
);

  logic [14:0] scaled;

  assign scaled  = 15'(x_i) * 15'(KYBER_Q) + 15'd4;
  assign coeff_o = COEFF_W'(scaled >> D_BITS);

endmodule

// File: rtl/unpack_cit_poly_decompress.sv
// Unpacks 3-byte groups of 3-bit compressed ciphertext coefficients and emits one
// decompressed 12-bit coefficient per handshake, KYBER_N coefficients per polynomial.
module unpack_cit_poly_decompress
  import unpack_cit_poly_decompress_pkg::*;
(
  input  logic                         i_Clk,
  input  logic                         i_Rst_n,
  unpack_cit_poly_decompress_if.slave  bus
);

  state_t             state_q;
  logic [1:0]         byteCnt_q;
  logic [2:0]         subIdx_q;
  logic [7:0]         coeffCnt_q;
  logic [23:0]        buf_q;
  logic [COEFF_W-1:0] coeff_q;
  logic               coeffValid_q;
  logic               byteReady_q;
  logic               busy_q;
  logic               done_q;

  logic [2:0]         subIdx_d;
  logic [D_BITS-1:0]  selX_d;
  logic [COEFF_W-1:0] coeff_d;
  logic               byteFire;
  logic               coeffFire;
  logic               lastCoeff;

  assign byteFire  = bus.i_Byte_Valid & byteReady_q;
  assign coeffFire = coeffValid_q & bus.i_Coeff_Ready;
  assign lastCoeff = (coeffCnt_q == 8'(KYBER_N - 1));

  // Select the field that becomes the next presented coefficient: field 0 when the
  // group completes loading, otherwise the one after the field currently on the output.
  always_comb begin
    subIdx_d = (state_q == EMIT) ? subIdx_q + 3'd1 : 3'd0;
    selX_d   = buf_q[D_BITS-1:0];
    for (int k = 0; k < COEFFS_PER_GROUP; k++) begin
      if (subIdx_d == 3'(k)) begin
        selX_d = buf_q[D_BITS*k +: D_BITS];
      end
    end
  end

  decompress_d3 u_decompress (
    .x_i     (selX_d),
    .coeff_o (coeff_d)
  );

  // Field 0 comes from byte 0, so it is already in buf_q when the third byte arrives.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= IDLE;
      byteCnt_q    <= 2'd0;
      subIdx_q     <= 3'd0;
      coeffCnt_q   <= 8'd0;
      buf_q        <= 24'd0;
      coeff_q      <= '0;
      coeffValid_q <= 1'b0;
      byteReady_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_Start) begin
            state_q     <= LOAD;
            busy_q      <= 1'b1;
            byteReady_q <= 1'b1;
            byteCnt_q   <= 2'd0;
            coeffCnt_q  <= 8'd0;
          end
        end

        LOAD: begin
          if (byteFire) begin
            case (byteCnt_q)
              2'd0:    buf_q[7:0]   <= bus.i_Byte;
              2'd1:    buf_q[15:8]  <= bus.i_Byte;
              default: buf_q[23:16] <= bus.i_Byte;
            endcase
            if (byteCnt_q == 2'(BYTES_PER_GROUP - 1)) begin
              byteCnt_q    <= 2'd0;
              byteReady_q  <= 1'b0;
              state_q      <= EMIT;
              subIdx_q     <= 3'd0;
              coeff_q      <= coeff_d;
              coeffValid_q <= 1'b1;
            end else begin
              byteCnt_q <= byteCnt_q + 2'd1;
            end
          end
        end

        EMIT: begin
          if (coeffFire) begin
            coeffCnt_q <= coeffCnt_q + 8'd1;
            if (subIdx_q == 3'(COEFFS_PER_GROUP - 1)) begin
              coeffValid_q <= 1'b0;
              if (lastCoeff) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q     <= LOAD;
                byteReady_q <= 1'b1;
              end
            end else begin
              subIdx_q <= subIdx_d;
              coeff_q  <= coeff_d;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_Byte_Ready  = byteReady_q;
  assign bus.o_Coeff       = coeff_q;
  assign bus.o_Coeff_Idx   = coeffCnt_q;
  assign bus.o_Coeff_Valid = coeffValid_q;
  assign bus.o_Busy        = busy_q;
  assign bus.o_Done        = done_q;

endmodule

// File: tb/tb_unpack_cit_poly_decompress.sv
// Self-checking bench: directed steps drive packed bytes, a scoreboard queue holds
// the expected coefficient/index stream, and a negedge monitor compares it.
module tb_unpack_cit_poly_decompress;
  import unpack_cit_poly_decompress_pkg::*;

  typedef struct {
    logic [COEFF_W-1:0] coeff;
    logic [7:0]         idx;
    bit                 last;
  } exp_t;

  localparam logic [COEFF_W-1:0] REF1 [8] = '{12'd0, 12'd416, 12'd832, 12'd1248,
                                              12'd1665, 12'd2081, 12'd2497, 12'd2913};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  unpack_cit_poly_decompress_if ifc ();

  unpack_cit_poly_decompress dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   nextIdx    = 0;
  bit   monitorEn  = 1'b0;
  bit   doneExp    = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [COEFF_W-1:0] modelCoeff(input logic [2:0] x);
    int v;
    v = int'(x);
    return COEFF_W'((v * KYBER_Q + 4) / 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [COEFF_W-1:0] c);
    exp_t e;
    e.coeff = c;
    e.idx   = 8'(nextIdx);
    e.last  = (nextIdx == KYBER_N - 1);
    sbQ.push_back(e);
    nextIdx = (nextIdx + 1) % KYBER_N;
  endtask

  task automatic pushModel(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [23:0] g;
    g = {b2, b1, b0};
    for (int j = 0; j < 8; j++) pushExp(modelCoeff(g[3*j +: 3]));
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCnt;
    waitCnt = 0;
    repeat (gap) tick();
    ifc.i_Byte       = b;
    ifc.i_Byte_Valid = 1'b1;
    @(negedge clk);
    while (ifc.o_Byte_Ready !== 1'b1 && waitCnt < 500) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 500) checkOutput("byteReadyTimeout", ifc.o_Byte_Ready, 1);
    tick();
    ifc.i_Byte_Valid = 1'b0;
    ifc.i_Byte       = 8'h00;
  endtask

  task automatic sendGroup(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int gap, input bit useModel);
    if (useModel) pushModel(b0, b1, b2);
    applyStimulus(b0, 0);
    applyStimulus(b1, gap);
    applyStimulus(b2, gap);
    checkOutput("firstCoeffLatency", ifc.o_Coeff_Valid, 1);
  endtask

  task automatic startPoly();
    ifc.i_Start = 1'b1;
    tick();
    ifc.i_Start = 1'b0;
    checkOutput("busyAfterStart", ifc.o_Busy, 1);
    checkOutput("byteReadyInLoad", ifc.o_Byte_Ready, 1);
  endtask

  task automatic drain(input bit toggle);
    int waitCnt;
    waitCnt = 0;
    while (sbQ.size() != 0 && waitCnt < 200) begin
      if (toggle) ifc.i_Coeff_Ready = (waitCnt % 2 == 0);
      tick();
      waitCnt++;
    end
    if (waitCnt >= 200) checkOutput("drainTimeout", sbQ.size(), 0);
    ifc.i_Coeff_Ready = 1'b1;
  endtask

  task automatic randGroup(input int gap);
    sendGroup(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), gap, 1'b1);
  endtask

  // Scoreboard monitor: compares the presented coefficient every valid cycle,
  // pops only on handshake, and expects o_Done exactly one cycle after the last one.
  always @(negedge clk) begin
    if (monitorEn && rst_n) begin
      checkOutput("doneFlag", ifc.o_Done, doneExp);
      if (doneExp) checkOutput("busyAtDone", ifc.o_Busy, 0);
      doneExp = 1'b0;
      if (ifc.o_Coeff_Valid === 1'b1) begin
        checkOutput("byteReadyInEmit", ifc.o_Byte_Ready, 0);
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedCoeffValid", ifc.o_Coeff_Valid, 0);
        end else begin
          checkOutput("coeff", ifc.o_Coeff, sbQ[0].coeff);
          checkOutput("coeffIdx", ifc.o_Coeff_Idx, sbQ[0].idx);
          if (ifc.i_Coeff_Ready) begin
            doneExp = sbQ[0].last;
            void'(sbQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ifc.i_Start       = 1'b0;
    ifc.i_Byte        = 8'h00;
    ifc.i_Byte_Valid  = 1'b0;
    ifc.i_Coeff_Ready = 1'b1;

    // Reset values
    #12;
    checkOutput("rstCoeffValid", ifc.o_Coeff_Valid, 0);
    checkOutput("rstCoeff", ifc.o_Coeff, 0);
    checkOutput("rstCoeffIdx", ifc.o_Coeff_Idx, 0);
    checkOutput("rstByteReady", ifc.o_Byte_Ready, 0);
    checkOutput("rstBusy", ifc.o_Busy, 0);
    checkOutput("rstDone", ifc.o_Done, 0);
    tick();
    rst_n     = 1'b1;
    monitorEn = 1'b1;
    tick();
    checkOutput("idleByteReady", ifc.o_Byte_Ready, 0);

    // Known group, ready held high
    startPoly();
    for (int j = 0; j < 8; j++) pushExp(REF1[j]);
    sendGroup(8'h88, 8'hC6, 8'hFA, 0, 1'b0);
    drain(1'b0);

    // Same group with 5-cycle byte gaps
    for (int j = 0; j < 8; j++) pushExp(REF1[j]);
    sendGroup(8'h88, 8'hC6, 8'hFA, 5, 1'b0);
    drain(1'b0);

    // Backpressure 1010 on coefficient ready
    ifc.i_Coeff_Ready = 1'b0;
    randGroup(0);
    drain(1'b1);

    // Stray start during LOAD
    pushModel(8'h5A, 8'hC3, 8'h0F);
    applyStimulus(8'h5A, 0);
    ifc.i_Start = 1'b1;
    tick();
    ifc.i_Start = 1'b0;
    applyStimulus(8'hC3, 0);
    applyStimulus(8'h0F, 0);
    checkOutput("firstCoeffLatency", ifc.o_Coeff_Valid, 1);
    drain(1'b0);

    // Stray start during EMIT while stalled
    ifc.i_Coeff_Ready = 1'b0;
    randGroup(0);
    ifc.i_Start = 1'b1;
    tick();
    ifc.i_Start = 1'b0;
    checkOutput("busyAfterStrayStart", ifc.o_Busy, 1);
    ifc.i_Coeff_Ready = 1'b1;
    drain(1'b0);

    // Complete the first polynomial
    for (int g = 5; g < KYBER_N / 8; g++) randGroup(0);
    drain(1'b0);
    tick();
    tick();
    checkOutput("busyIdleAfterPoly", ifc.o_Busy, 0);

    // Full random polynomial, back-to-back
    startPoly();
    for (int g = 0; g < KYBER_N / 8; g++) randGroup(0);
    drain(1'b0);
    tick();
    tick();
    checkOutput("busyIdleAfterPoly2", ifc.o_Busy, 0);

    // Reset mid-polynomial
    startPoly();
    for (int g = 0; g < 12; g++) randGroup(0);
    drain(1'b0);
    randGroup(0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abortCoeffValid", ifc.o_Coeff_Valid, 0);
    checkOutput("abortCoeff", ifc.o_Coeff, 0);
    checkOutput("abortCoeffIdx", ifc.o_Coeff_Idx, 0);
    checkOutput("abortByteReady", ifc.o_Byte_Ready, 0);
    checkOutput("abortBusy", ifc.o_Busy, 0);
    checkOutput("abortDone", ifc.o_Done, 0);
    sbQ.delete();
    nextIdx = 0;
    doneExp = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("noAutoRestart", ifc.o_Busy, 0);
    startPoly();
    randGroup(0);
    drain(1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
